// File: rtl/mqst_top.sv
// Manchester (IEEE 802.3) byte codec: framed serial encoder plus independent decoder.
// Define MQST_PARITY_EN to append and check an even-parity bit after data bit 0.
module mqst_top #(
   parameter int HALF_BIT_CLKS = 4,
   parameter int GAP_BITS      = 1
) (
   input  logic       clk,
   input  logic       rst_p,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_tready,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       Mqst_BitIn,
   output logic       Mqst_BitOut
);

   localparam int CW       = $clog2(2*HALF_BIT_CLKS + 1);
   localparam int GAP_CLKS = GAP_BITS*2*HALF_BIT_CLKS;

   localparam logic [CW-1:0] BIT_LAST_C = CW'(2*HALF_BIT_CLKS - 1);
   localparam logic [CW-1:0] HALF_M1_C  = CW'(HALF_BIT_CLKS - 1);
   localparam logic [CW-1:0] HALF_P1_C  = CW'(HALF_BIT_CLKS + 1);
   localparam logic [CW-1:0] SAMP_A_C   = CW'(HALF_BIT_CLKS/2);
   localparam logic [CW-1:0] SAMP_B_C   = CW'(HALF_BIT_CLKS + HALF_BIT_CLKS/2);
   localparam logic [15:0]   GAP_LAST_C = 16'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_GAP} tx_state_e;
   typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_PARITY} rx_state_e;

   tx_state_e         tx_state_q, tx_state_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [2:0]        tx_idx_q, tx_idx_d;
   logic [7:0]        tx_shift_q, tx_shift_d;
   logic              tx_bit_q, tx_bit_d;
   logic [15:0]       gap_cnt_q, gap_cnt_d;
   logic              bit_out_q, bit_out_d;
   logic              tready_q, tready_d;
   logic              tx_next_bit;
   logic              tx_to_gap;
`ifdef MQST_PARITY_EN
   logic              tx_par_q, tx_par_d;
`endif

   rx_state_e         rx_state_q, rx_state_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_idx_q, rx_idx_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic              rx_a_q, rx_a_d;
   logic [1:0]        sync_q, sync_d;
   logic              prev_q, prev_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              data_out_valid_q, data_out_valid_d;
   logic              rx_line;
   logic              rx_edge;
   logic              rx_rise;

   // Encoder: each bit is sent as ~bit for the first half and bit for the second half.
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_idx_d    = tx_idx_q;
      tx_shift_d  = tx_shift_q;
      tx_bit_d    = tx_bit_q;
      gap_cnt_d   = gap_cnt_q;
      bit_out_d   = 1'b0;
      tready_d    = 1'b0;
      tx_next_bit = tx_bit_q;
      tx_to_gap   = 1'b0;
`ifdef MQST_PARITY_EN
      tx_par_d    = tx_par_q;
`endif
      case (tx_state_q)
         TX_IDLE: begin
            tready_d = 1'b1;
            if (data_in_valid && tready_q) begin
               tx_shift_d = data_in;
               tx_state_d = TX_START;
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_bit_d   = 1'b0;
               bit_out_d  = 1'b1;
               tready_d   = 1'b0;
`ifdef MQST_PARITY_EN
               tx_par_d   = ^data_in;
`endif
            end
         end
         TX_GAP: begin
            if (gap_cnt_q == GAP_LAST_C) begin
               tx_state_d = TX_IDLE;
               tready_d   = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         default: begin
            if (tx_cnt_q == BIT_LAST_C) begin
               tx_cnt_d = '0;
               case (tx_state_q)
                  TX_START: begin
                     tx_state_d  = TX_DATA;
                     tx_next_bit = tx_shift_q[7];
                  end
                  TX_DATA: begin
                     if (tx_idx_q == 3'd7) begin
`ifdef MQST_PARITY_EN
                        tx_state_d  = TX_PARITY;
                        tx_next_bit = tx_par_q;
`else
                        tx_to_gap = 1'b1;
`endif
                     end else begin
                        tx_idx_d    = tx_idx_q + 3'd1;
                        tx_shift_d  = {tx_shift_q[6:0], 1'b0};
                        tx_next_bit = tx_shift_q[6];
                     end
                  end
                  default: tx_to_gap = 1'b1;
               endcase
               tx_bit_d = tx_next_bit;
               if (tx_to_gap) begin
                  gap_cnt_d = '0;
                  if (GAP_CLKS == 0) begin
                     tx_state_d = TX_IDLE;
                     tready_d   = 1'b1;
                  end else begin
                     tx_state_d = TX_GAP;
                  end
               end else begin
                  bit_out_d = ~tx_next_bit;
               end
            end else begin
               tx_cnt_d  = tx_cnt_q + CW'(1);
               bit_out_d = (tx_cnt_q >= HALF_M1_C) ? tx_bit_q : ~tx_bit_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_bit_q   <= 1'b0;
         gap_cnt_q  <= '0;
         bit_out_q  <= 1'b0;
         tready_q   <= 1'b0;
`ifdef MQST_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         gap_cnt_q  <= gap_cnt_d;
         bit_out_q  <= bit_out_d;
         tready_q   <= tready_d;
`ifdef MQST_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   assign rx_line = sync_q[1];
   assign rx_edge = rx_line ^ prev_q;
   assign rx_rise = rx_line & ~prev_q;

   // Decoder: a mid-bit edge near HALF_BIT_CLKS re-centres the bit counter to absorb drift.
   always_comb begin
      sync_d           = {sync_q[0], Mqst_BitIn};
      prev_d           = rx_line;
      rx_state_d       = rx_state_q;
      rx_cnt_d         = rx_cnt_q;
      rx_idx_d         = rx_idx_q;
      rx_shift_d       = rx_shift_q;
      rx_a_d           = rx_a_q;
      data_out_d       = data_out_q;
      data_out_valid_d = 1'b0;
      if (rx_state_q == RX_HUNT) begin
         if (rx_rise) begin
            rx_state_d = RX_START;
            rx_cnt_d   = CW'(1);
            rx_idx_d   = '0;
         end
      end else begin
         if (rx_edge && (rx_cnt_q >= HALF_M1_C) && (rx_cnt_q <= HALF_P1_C)) begin
            rx_cnt_d = HALF_P1_C;
         end else if (rx_cnt_q == BIT_LAST_C) begin
            rx_cnt_d = '0;
         end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
         end
         if (rx_cnt_q == SAMP_A_C) begin
            rx_a_d = rx_line;
         end
         if (rx_cnt_q == SAMP_B_C) begin
            if (rx_a_q == rx_line) begin
               rx_state_d = RX_HUNT;
            end else begin
               case (rx_state_q)
                  RX_START: rx_state_d = rx_line ? RX_HUNT : RX_DATA;
                  RX_DATA: begin
                     rx_shift_d = {rx_shift_q[6:0], rx_line};
                     if (rx_idx_q == 3'd7) begin
`ifdef MQST_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        data_out_d       = {rx_shift_q[6:0], rx_line};
                        data_out_valid_d = 1'b1;
                        rx_state_d       = RX_HUNT;
`endif
                     end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                     end
                  end
`ifdef MQST_PARITY_EN
                  RX_PARITY: begin
                     if ((^rx_shift_q) == rx_line) begin
                        data_out_d       = rx_shift_q;
                        data_out_valid_d = 1'b1;
                     end
                     rx_state_d = RX_HUNT;
                  end
`endif
                  default: rx_state_d = RX_HUNT;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         sync_q           <= '0;
         prev_q           <= 1'b0;
         rx_state_q       <= RX_HUNT;
         rx_cnt_q         <= '0;
         rx_idx_q         <= '0;
         rx_shift_q       <= '0;
         rx_a_q           <= 1'b0;
         data_out_q       <= 8'h00;
         data_out_valid_q <= 1'b0;
      end else begin
         sync_q           <= sync_d;
         prev_q           <= prev_d;
         rx_state_q       <= rx_state_d;
         rx_cnt_q         <= rx_cnt_d;
         rx_idx_q         <= rx_idx_d;
         rx_shift_q       <= rx_shift_d;
         rx_a_q           <= rx_a_d;
         data_out_q       <= data_out_d;
         data_out_valid_q <= data_out_valid_d;
      end
   end

   assign data_tready    = tready_q;
   assign Mqst_BitOut    = bit_out_q;
   assign data_out       = data_out_q;
   assign data_out_valid = data_out_valid_q;

endmodule

// File: tb/tb_mqst_top.sv
// Scoreboard bench for mqst_top: loopback, line encoding, handshake, violations and mid-frame reset.
module tb_mqst_top;

   localparam int H        = 4;
   localparam int GAP      = 1;
   localparam int BIT_CLKS = 2*H;
`ifdef MQST_PARITY_EN
   localparam int FRAME_BITS = 10;
`else
   localparam int FRAME_BITS = 9;
`endif
   localparam int FRAME_CLKS = FRAME_BITS*BIT_CLKS;
   localparam int TOTAL_CLKS = FRAME_CLKS + GAP*BIT_CLKS;

   logic       clk = 1'b0;
   logic       rst_p = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_tready;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       bit_in;
   logic       bit_out;
   logic       loop_en = 1'b1;
   logic       inj_bit = 1'b0;

   int         checks = 0;
   int         errors = 0;
   int         rx_count = 0;
   int         acc_count = 0;
   int         r0;
   int         a0;
   logic [7:0] d0;
   logic       prev_valid = 1'b0;
   logic [7:0] exp_q[$];

   assign bit_in = loop_en ? bit_out : inj_bit;

   always #5 clk = ~clk;

   mqst_top #(.HALF_BIT_CLKS(H), .GAP_BITS(GAP)) dut (
      .clk            (clk),
      .rst_p          (rst_p),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_tready    (data_tready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .Mqst_BitIn     (bit_in),
      .Mqst_BitOut    (bit_out)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference line level j clocks after the accepting edge (0 beyond the frame).
   function automatic logic expLevel(input logic [7:0] b, input int j);
      int   bi;
      int   off;
      logic v;
      bi  = j / BIT_CLKS;
      off = j % BIT_CLKS;
      if (bi >= FRAME_BITS) return 1'b0;
      if (bi == 0) v = 1'b0;
      else if (bi <= 8) v = b[3'(8 - bi)];
      else v = ^b;
      return (off < H) ? ~v : v;
   endfunction

   task automatic applyStimulus(input logic [7:0] b, input bit hold);
      int t;
      @(negedge clk);
      data_in       = b;
      data_in_valid = 1'b1;
      t = 0;
      while (!data_tready && t < 200) begin
         @(negedge clk);
         t++;
      end
      checkOutput("tready_wait", 32'(data_tready), 1);
      if (!data_tready) begin
         data_in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(b);
      #1;
      if (!hold) data_in_valid = 1'b0;
   endtask

   task automatic waitRx(input int max_clks);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < max_clks) begin
         @(negedge clk);
         t++;
      end
      checkOutput("rx_drain", 32'(exp_q.size()), 0);
   endtask

   task automatic driveFrame(input logic [7:0] b, input int bad_bit, input bit flip);
      logic lvl;
      loop_en = 1'b0;
      inj_bit = 1'b0;
      for (int j = 0; j < FRAME_CLKS; j++) begin
         @(negedge clk);
         lvl = expLevel(b, j);
         if (j / BIT_CLKS == bad_bit) lvl = flip ? ~lvl : 1'b1;
         inj_bit = lvl;
      end
      @(negedge clk);
      inj_bit = 1'b0;
      repeat (5*BIT_CLKS) @(negedge clk);
   endtask

   always @(posedge clk) begin
      if (!rst_p && data_in_valid && data_tready) acc_count <= acc_count + 1;
   end

   always @(negedge clk) begin
      if (rst_p) begin
         prev_valid = 1'b0;
      end else begin
         if (data_out_valid) begin
            rx_count++;
            checkOutput("valid_pulse", 32'(prev_valid), 0);
            if (exp_q.size() == 0) checkOutput("rx_unexpected", 32'(exp_q.size()), 1);
            else checkOutput("rx_byte", 32'(data_out), 32'(exp_q.pop_front()));
         end
         prev_valid = data_out_valid;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_p = 1'b1;
      #98;
      checkOutput("rst_bitout", 32'(bit_out), 0);
      checkOutput("rst_tready", 32'(data_tready), 0);
      checkOutput("rst_valid", 32'(data_out_valid), 0);
      checkOutput("rst_data_out", 32'(data_out), 0);
      #2;
      rst_p = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("tready_after_rst", 32'(data_tready), 1);

      $display("[TB] encoding and handshake, byte 0xA5");
      a0 = acc_count;
      applyStimulus(8'hA5, 1'b1);
      for (int j = 0; j < TOTAL_CLKS; j++) begin
         @(negedge clk);
         checkOutput("bitout_A5", 32'(bit_out), 32'(expLevel(8'hA5, j)));
         checkOutput("tready_busy", 32'(data_tready), 0);
      end
      @(negedge clk);
      checkOutput("tready_gap_end", 32'(data_tready), 1);
      data_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("accept_once", 32'(acc_count - a0), 1);
      waitRx(200);

      $display("[TB] loopback bytes 0..11");
      r0 = rx_count;
      for (int i = 0; i < 12; i++) applyStimulus(8'(i), 1'b0);
      waitRx(400);
      checkOutput("loop_count", 32'(rx_count - r0), 12);
      repeat (2*BIT_CLKS) @(negedge clk);
      checkOutput("line_idle", 32'(bit_out), 0);
      checkOutput("tready_idle", 32'(data_tready), 1);

      $display("[TB] violation in data bit 3");
      r0 = rx_count;
      d0 = data_out;
      driveFrame(8'h5A, 5, 1'b0);
      checkOutput("viol_no_valid", 32'(rx_count - r0), 0);
      checkOutput("viol_data_hold", 32'(data_out), 32'(d0));
      loop_en = 1'b1;
      applyStimulus(8'h3C, 1'b0);
      waitRx(300);
      checkOutput("after_viol", 32'(data_out), 32'h3C);

`ifdef MQST_PARITY_EN
      $display("[TB] parity bit for 0x07");
      applyStimulus(8'h07, 1'b0);
      repeat (9*BIT_CLKS + 2) @(negedge clk);
      checkOutput("parity_half0", 32'(bit_out), 0);
      repeat (H) @(negedge clk);
      checkOutput("parity_half1", 32'(bit_out), 1);
      waitRx(300);
      r0 = rx_count;
      d0 = data_out;
      driveFrame(8'h07, 9, 1'b1);
      checkOutput("parity_drop", 32'(rx_count - r0), 0);
      checkOutput("parity_data_hold", 32'(data_out), 32'(d0));
      loop_en = 1'b1;
`endif

      $display("[TB] reset during data bit 4");
      r0 = rx_count;
      applyStimulus(8'hC3, 1'b0);
      repeat (4*BIT_CLKS + 2) @(negedge clk);
      checkOutput("pre_rst_bitout", 32'(bit_out), 32'(expLevel(8'hC3, 4*BIT_CLKS + 1)));
      rst_p = 1'b1;
      #1;
      checkOutput("rst_mid_bitout", 32'(bit_out), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      checkOutput("rst_mid_tready", 32'(data_tready), 0);
      rst_p = 1'b0;
      repeat (12*BIT_CLKS) @(negedge clk);
      checkOutput("rst_mid_no_valid", 32'(rx_count - r0), 0);
      checkOutput("rst_mid_data_out", 32'(data_out), 0);
      applyStimulus(8'h81, 1'b0);
      waitRx(300);
      checkOutput("after_rst", 32'(data_out), 32'h81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
